// File: rtl/product_accumulator.sv
// Accumulates a frame of 6x6 multiplier products into an ACC_W-bit sum with a valid/ready handshake on both sides.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
   parameter int LEN   = 8,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [11:0]      product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf,
   output logic [7:0]       count
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state, state_next;
   logic [ACC_W-1:0] acc, acc_next, acc_add;
   logic [7:0]       count_next, count_inc;
   logic             ovf_next;
   logic [ACC_W:0]   sum;
   logic             in_xfer, out_xfer;

   // Handshake outputs depend on state alone, so neither ready nor valid loops back combinationally.
   assign in_ready  = (state != DONE);
   assign out_valid = (state == DONE);
   assign acc_out   = acc;

   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign count_inc = count + 8'd1;

   // The extra top bit of the sum is the carry that flags overflow.
   always_comb begin
      sum = {1'b0, acc} + (ACC_W+1)'(product);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_add = sum[ACC_W-1:0];
`endif
   end

   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      ovf_next   = ovf;
      case (state)
         IDLE: begin
            if (in_xfer) begin
               acc_next   = ACC_W'(product);
               count_next = 8'd1;
               ovf_next   = 1'b0;
               state_next = ((LEN == 1) || in_last) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_xfer) begin
               acc_next   = acc_add;
               count_next = count_inc;
               ovf_next   = ovf | sum[ACC_W];
               if ((count_inc == 8'(LEN)) || in_last)
                  state_next = DONE;
            end
         end
         DONE: begin
            if (out_xfer) begin
               state_next = IDLE;
               acc_next   = '0;
               count_next = 8'd0;
               ovf_next   = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort wins over any transfer landing on the same edge.
      if (clr) begin
         state_next = IDLE;
         acc_next   = '0;
         count_next = 8'd0;
         ovf_next   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= 8'd0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
         ovf   <= ovf_next;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: three instances (LEN=8/ACC_W=16, LEN=8/ACC_W=12, LEN=1/ACC_W=16)
// driven by directed frames; a monitor checks every output transfer against queued expectations.
module tb_product_accumulator;

   typedef struct {
      int inst;
      int acc;
      int ovf;
      int cnt;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [2:0]        clr, in_valid, in_ready, in_last, out_valid, out_ready, ovf;
   logic [2:0][11:0]  product;
   logic [2:0][7:0]   count;
   logic [15:0]       acc0, acc2;
   logic [11:0]       acc1;
   logic [2:0][31:0]  acc_w;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   assign acc_w[0] = {16'd0, acc0};
   assign acc_w[1] = {20'd0, acc1};
   assign acc_w[2] = {16'd0, acc2};

   product_accumulator #(.LEN(8), .ACC_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .product(product[0]), .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .acc_out(acc0), .ovf(ovf[0]), .count(count[0]));

   product_accumulator #(.LEN(8), .ACC_W(12)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .product(product[1]), .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .acc_out(acc1), .ovf(ovf[1]), .count(count[1]));

   product_accumulator #(.LEN(1), .ACC_W(16)) u2 (
      .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .product(product[2]), .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .acc_out(acc2), .ovf(ovf[2]), .count(count[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offer one product and wait (bounded) for the input transfer.
   task automatic applyStimulus(input int k, input int p, input bit last);
      bit accepted = 0;
      in_valid[k] = 1'b1;
      product[k]  = 12'(p);
      in_last[k]  = last;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (in_ready[k]) accepted = 1;
         tick();
      end
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic expectFrame(input int k, input int a, input int o, input int c);
      exp_t e;
      e.inst = k;
      e.acc  = a;
      e.ovf  = o;
      e.cnt  = c;
      sb.push_back(e);
   endtask

   // Monitor: any output transfer about to happen on the next edge is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && out_ready[k] && !clr[k]) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_output", k, -1);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  checkOutput("frame_inst", k, e.inst);
                  checkOutput("frame_acc", int'(acc_w[k]), e.acc);
                  checkOutput("frame_ovf", int'(ovf[k]), e.ovf);
                  checkOutput("frame_count", int'(count[k]), e.cnt);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      bit stable;
      int ovf_exp;
      rst_n     = 1'b0;
      clr       = '0;
      in_valid  = '0;
      in_last   = '0;
      out_ready = 3'b111;
      product   = '0;
      #3;
      checkOutput("reset_in_ready", int'(in_ready[0]), 1);
      checkOutput("reset_out_valid", int'(out_valid[0]), 0);
      checkOutput("reset_acc", int'(acc_w[0]), 0);
      checkOutput("reset_count", int'(count[0]), 0);
      #4 rst_n = 1'b1;
      tick(2);

      $display("[TB] basic frame");
      expectFrame(0, 31752, 0, 8);
      for (int i = 0; i < 7; i++) applyStimulus(0, 3969, 0);
      checkOutput("basic_not_done_yet", int'(out_valid[0]), 0);
      applyStimulus(0, 3969, 0);
      checkOutput("basic_out_valid", int'(out_valid[0]), 1);
      checkOutput("basic_count", int'(count[0]), 8);
      tick();
      checkOutput("basic_idle_in_ready", int'(in_ready[0]), 1);
      checkOutput("basic_idle_count", int'(count[0]), 0);

      $display("[TB] early end with stalls");
      expectFrame(0, 60, 0, 3);
      applyStimulus(0, 10, 0);
      tick(2);
      applyStimulus(0, 20, 0);
      tick(2);
      checkOutput("stall_count_hold", int'(count[0]), 2);
      checkOutput("stall_acc_hold", int'(acc_w[0]), 30);
      applyStimulus(0, 30, 1);
      checkOutput("early_out_valid", int'(out_valid[0]), 1);
      checkOutput("early_acc", int'(acc_w[0]), 60);
      tick();
      checkOutput("early_back_idle", int'(out_valid[0]), 0);

      $display("[TB] backpressure");
      out_ready[0] = 1'b0;
      expectFrame(0, 300, 0, 2);
      applyStimulus(0, 100, 0);
      applyStimulus(0, 200, 1);
      in_valid[0] = 1'b1;
      product[0]  = 12'd55;
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         if (in_ready[0] || !out_valid[0] || acc_w[0] != 300 || count[0] != 2) stable = 0;
         tick();
      end
      checkOutput("bp_held_stable", int'(stable), 1);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      checkOutput("bp_released_idle", int'(out_valid[0]), 0);
      checkOutput("bp_nothing_taken", int'(count[0]), 0);

      $display("[TB] overflow");
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      ovf_exp = 4095;
`else
      ovf_exp = 104;
`endif
      expectFrame(1, ovf_exp, 1, 2);
      applyStimulus(1, 4000, 0);
      checkOutput("ovf_clear_before", int'(ovf[1]), 0);
      applyStimulus(1, 200, 1);
      checkOutput("ovf_flag", int'(ovf[1]), 1);
      tick();

      $display("[TB] abort");
      for (int i = 1; i <= 4; i++) applyStimulus(0, i, 0);
      checkOutput("abort_pre_count", int'(count[0]), 4);
      in_valid[0] = 1'b1;
      product[0]  = 12'd5;
      clr[0]      = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      clr[0]      = 1'b0;
      checkOutput("abort_count", int'(count[0]), 0);
      checkOutput("abort_acc", int'(acc_w[0]), 0);
      checkOutput("abort_in_ready", int'(in_ready[0]), 1);
      expectFrame(0, 15, 0, 2);
      applyStimulus(0, 7, 0);
      applyStimulus(0, 8, 1);
      tick();

      $display("[TB] async reset mid-frame");
      applyStimulus(0, 500, 0);
      applyStimulus(0, 600, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_count", int'(count[0]), 0);
      checkOutput("rst_async_acc", int'(acc_w[0]), 0);
      checkOutput("rst_async_in_ready", int'(in_ready[0]), 1);
      #3 rst_n = 1'b1;
      tick(3);
      checkOutput("rst_no_output", int'(out_valid[0]), 0);

      $display("[TB] single-product frame");
      expectFrame(2, 1234, 0, 1);
      applyStimulus(2, 1234, 0);
      checkOutput("len1_out_valid", int'(out_valid[2]), 1);
      checkOutput("len1_acc", int'(acc_w[2]), 1234);
      tick(3);

      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
